divide_unit: RTL and testbench

DIVIDE_UNIT -- requirements
Module: divide_unit

---
 rtl/divide_unit.sv | 148 ++++++++++++++
 tb/tb_divide_unit.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/divide_unit.sv
// rtl/divide_unit.sv - RV32M DIV/DIVU/REM/REMU restoring divider, one quotient bit per cycle.
// Optional macro DIVIDE_UNIT_EARLY_EXIT_EN: finish divide-by-zero and signed overflow at accept.
module divide_unit (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        r_valid,
    input  logic        r_ready,
    output logic [31:0] r
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nx;

    logic        sel_rem;
    logic        q_neg;
    logic        r_neg;
    logic [4:0]  cnt;
    logic [31:0] dq;
    logic [31:0] rem;
    logic [31:0] dvs;

    logic        is_signed;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic        div_zero;
    logic        ovf;
    logic        early;

    logic [32:0] rem_sh;
    logic [32:0] diff;
    logic        q_bit;
    logic [31:0] q_res;
    logic [31:0] r_res;

    always_comb begin
        is_signed = ~op[0];
        a_neg     = is_signed & a[31];
        b_neg     = is_signed & b[31];
        a_mag     = a_neg ? (32'd0 - a) : a;
        b_mag     = b_neg ? (32'd0 - b) : b;
        div_zero  = (b == 32'd0);
        ovf       = is_signed && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
`ifdef DIVIDE_UNIT_EARLY_EXIT_EN
        early     = div_zero | ovf;
`else
        early     = 1'b0;
`endif
    end

    // Trial subtraction on the 33-bit shifted partial remainder; borrow means restore.
    always_comb begin
        rem_sh = {rem, dq[31]};
        diff   = rem_sh - {1'b0, dvs};
        q_bit  = ~diff[32];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    state_nx = early ? DONE : RUN;
                end
            end
            RUN: begin
                if (cnt == 5'd31) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                if (r_ready) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sel_rem <= 1'b0;
            q_neg   <= 1'b0;
            r_neg   <= 1'b0;
            cnt     <= 5'd0;
            dq      <= 32'd0;
            rem     <= 32'd0;
            dvs     <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sel_rem <= op[1];
                        // A zero divisor yields an all-ones magnitude that must stay unsigned.
                        q_neg   <= (a_neg ^ b_neg) & ~div_zero;
                        r_neg   <= a_neg;
                        cnt     <= 5'd0;
                        dvs     <= b_mag;
                        dq      <= a_mag;
                        rem     <= 32'd0;
`ifdef DIVIDE_UNIT_EARLY_EXIT_EN
                        if (div_zero) begin
                            dq  <= 32'hFFFF_FFFF;
                            rem <= a_mag;
                        end
`endif
                    end
                end
                RUN: begin
                    dq  <= {dq[30:0], q_bit};
                    rem <= q_bit ? diff[31:0] : rem_sh[31:0];
                    cnt <= cnt + 5'd1;
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        q_res    = q_neg ? (32'd0 - dq) : dq;
        r_res    = r_neg ? (32'd0 - rem) : rem;
        in_ready = (state == IDLE);
        r_valid  = (state == DONE);
        r        = r_valid ? (sel_rem ? r_res : q_res) : 32'd0;
    end

endmodule

// File: tb/tb_divide_unit.sv
// tb/tb_divide_unit.sv - scoreboard bench for divide_unit with directed RV32M vectors.
module tb_divide_unit;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        r_ready = 1'b0;
    logic [1:0]  op = 2'd0;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic        in_ready;
    logic        r_valid;
    logic [31:0] r;

    localparam logic [1:0] OP_DIV  = 2'd0;
    localparam logic [1:0] OP_DIVU = 2'd1;
    localparam logic [1:0] OP_REM  = 2'd2;
    localparam logic [1:0] OP_REMU = 2'd3;

    divide_unit dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .op       (op),
        .a        (a),
        .b        (b),
        .r_valid  (r_valid),
        .r_ready  (r_ready),
        .r        (r)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    typedef struct {
        logic [31:0] res;
        int          lat;
        int          acc;
        string       name;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    logic seen = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int exp_lat(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
`ifdef DIVIDE_UNIT_EARLY_EXIT_EN
        if (y == 32'd0) return 1;
        if (!o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 1;
`else
        if (o == 2'd0 && x == 32'd0 && y == 32'd0) return 32;
`endif
        return 32;
    endfunction

    always @(negedge clk) begin
        if (r_valid && !seen) begin
            seen = 1'b1;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: got %h expected no result", r);
            end else begin
                mon_e = sb.pop_front();
                check({mon_e.name, "_result"}, r, mon_e.res);
                check({mon_e.name, "_latency"}, 32'(cyc - mon_e.acc), 32'(mon_e.lat));
            end
        end else if (!r_valid) begin
            seen = 1'b0;
        end
    end

    task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] x,
                          input logic [31:0] y, input logic [31:0] exp, input int hold);
        exp_t e;
        bit   got;
        @(negedge clk);
        op = o; a = x; b = y; in_valid = 1'b1;
        check({name, "_in_ready_idle"}, 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        e.res = exp; e.lat = exp_lat(o, x, y); e.acc = cyc; e.name = name;
        sb.push_back(e);
        in_valid = 1'b0; a = $urandom; b = $urandom; op = 2'($urandom_range(3, 0));
        check({name, "_in_ready_busy"}, 32'(in_ready), 32'd0);
        got = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            if (r_valid) got = 1'b1;
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got no r_valid expected r_valid within 100 cycles", name);
            return;
        end
        in_valid = (hold > 0);
        for (int i = 0; i < hold; i++) begin
            check({name, "_hold_r"}, r, exp);
            check({name, "_hold_r_valid"}, 32'(r_valid), 32'd1);
            check({name, "_hold_in_ready"}, 32'(in_ready), 32'd0);
            @(negedge clk);
        end
        r_ready = 1'b1;
        @(posedge clk);
        #1;
        r_ready = 1'b0;
        check({name, "_release_in_ready"}, 32'(in_ready), 32'd1);
        check({name, "_release_r"}, r, 32'd0);
        in_valid = 1'b0;
    endtask

    initial begin
        #1;
        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_r_valid", 32'(r_valid), 32'd0);
        check("reset_r", r, 32'd0);
        repeat (2) @(posedge clk);
        #3 reset_n = 1'b1;

        run_op("divu_100_7",   OP_DIVU, 32'd100,         32'd7,           32'd14,          0);
        run_op("remu_100_7",   OP_REMU, 32'd100,         32'd7,           32'd2,           0);
        run_op("div_m7_2",     OP_DIV,  32'hFFFF_FFF9,   32'd2,           32'hFFFF_FFFD,   0);
        run_op("rem_m7_2",     OP_REM,  32'hFFFF_FFF9,   32'd2,           32'hFFFF_FFFF,   0);
        run_op("div_7_m2",     OP_DIV,  32'd7,           32'hFFFF_FFFE,   32'hFFFF_FFFD,   0);
        run_op("rem_7_m2",     OP_REM,  32'd7,           32'hFFFF_FFFE,   32'd1,           0);
        run_op("divu_5_0",     OP_DIVU, 32'd5,           32'd0,           32'hFFFF_FFFF,   0);
        run_op("rem_5_0",      OP_REM,  32'd5,           32'd0,           32'd5,           0);
        run_op("div_m8_0",     OP_DIV,  32'hFFFF_FFF8,   32'd0,           32'hFFFF_FFFF,   0);
        run_op("rem_m8_0",     OP_REM,  32'hFFFF_FFF8,   32'd0,           32'hFFFF_FFF8,   0);
        run_op("remu_big_0",   OP_REMU, 32'hF000_0001,   32'd0,           32'hF000_0001,   0);
        run_op("div_ovf",      OP_DIV,  32'h8000_0000,   32'hFFFF_FFFF,   32'h8000_0000,   0);
        run_op("rem_ovf",      OP_REM,  32'h8000_0000,   32'hFFFF_FFFF,   32'd0,           0);
        run_op("divu_max_1",   OP_DIVU, 32'hFFFF_FFFF,   32'd1,           32'hFFFF_FFFF,   0);
        run_op("divu_2g_3",    OP_DIVU, 32'h8000_0000,   32'd3,           32'h2AAA_AAAA,   0);
        run_op("remu_2g_3",    OP_REMU, 32'h8000_0000,   32'd3,           32'd2,           0);
        run_op("divu_hold",    OP_DIVU, 32'd1000,        32'd10,          32'd100,         10);

        @(negedge clk);
        op = OP_DIVU; a = 32'h0000_FFFF; b = 32'd7; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (15) @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("midrun_reset_r_valid", 32'(r_valid), 32'd0);
        check("midrun_reset_in_ready", 32'(in_ready), 32'd1);
        check("midrun_reset_r", r, 32'd0);
        @(posedge clk);
        #3 reset_n = 1'b1;
        run_op("divu_9_3",     OP_DIVU, 32'd9,           32'd3,           32'd3,           0);

        repeat (40) @(negedge clk);
        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no finish expected finish before time limit");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1);
    end

endmodule
